// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: instruction fields from EX/MEM + mem_stage read data in,
// registered writeback entry and retire count out.
interface mem_wb_stage_if #(
  parameter int unsigned CNT_W = 32
);
  logic             valid_in;
  logic             stall;
  logic             flush;
  logic             reg_write_in;
  logic [4:0]       rd_in;
  logic [1:0]       wb_sel_in;
  logic [2:0]       funct3_in;
  logic [31:0]      alu_result_in;
  logic [31:0]      mem_data_in;
  logic [31:0]      pc_plus4_in;

  logic             wb_valid;
  logic             wb_reg_write;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;
  logic             wb_load_fault;
  logic [CNT_W-1:0] instret;

  // Upstream pipeline / consumer side
  modport master (
    output valid_in, stall, flush, reg_write_in, rd_in, wb_sel_in, funct3_in,
           alu_result_in, mem_data_in, pc_plus4_in,
    input  wb_valid, wb_reg_write, wb_rd, wb_data, wb_load_fault, instret
  );

  // The MEM/WB stage itself
  modport slave (
    input  valid_in, stall, flush, reg_write_in, rd_in, wb_sel_in, funct3_in,
           alu_result_in, mem_data_in, pc_plus4_in,
    output wb_valid, wb_reg_write, wb_rd, wb_data, wb_load_fault, instret
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load extraction/extension, writeback source
// select, registered writeback entry and retired-instruction counter.
module mem_wb_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input logic           clk,
  input logic           rst,
  mem_wb_stage_if.slave bus
);

  logic [1:0]      off;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic            ld_bad;
  logic [XLEN-1:0] ld_data;
  logic            is_load;
  logic [XLEN-1:0] data_d;
  logic            we_d;
  logic            fault_d;

  logic             valid_q;
  logic             we_q;
  logic [4:0]       rd_q;
  logic [XLEN-1:0]  data_q;
  logic             fault_q;
  logic [CNT_W-1:0] instret_q;

  assign off = bus.alu_result_in[1:0];

  // Byte/half lane selection, then extension and alignment/legality check
  always_comb begin
    byte_v = bus.mem_data_in[7:0];
    unique case (off)
      2'd0: byte_v = bus.mem_data_in[7:0];
      2'd1: byte_v = bus.mem_data_in[15:8];
      2'd2: byte_v = bus.mem_data_in[23:16];
      2'd3: byte_v = bus.mem_data_in[31:24];
      default: byte_v = bus.mem_data_in[7:0];
    endcase
    half_v  = off[1] ? bus.mem_data_in[31:16] : bus.mem_data_in[15:0];
    ld_bad  = 1'b0;
    ld_data = '0;
    case (bus.funct3_in)
      3'b000: ld_data = {{24{byte_v[7]}}, byte_v};
      3'b100: ld_data = {24'b0, byte_v};
      3'b001: begin
        ld_bad  = off[0];
        ld_data = {{16{half_v[15]}}, half_v};
      end
      3'b101: begin
        ld_bad  = off[0];
        ld_data = {16'b0, half_v};
      end
      3'b010: begin
        ld_bad  = (off != 2'b00);
        ld_data = bus.mem_data_in;
      end
      default: ld_bad = 1'b1;
    endcase
    if (ld_bad) ld_data = '0;
  end

  // Writeback source select and write-enable qualification
  always_comb begin
    is_load = (bus.wb_sel_in == 2'b01);
    case (bus.wb_sel_in)
      2'b00:   data_d = bus.alu_result_in;
      2'b01:   data_d = ld_data;
      2'b10:   data_d = bus.pc_plus4_in;
      default: data_d = '0;
    endcase
    fault_d = bus.valid_in & is_load & ld_bad;
    // x0 is never written; reserved select and bad loads suppress the write
    we_d = bus.valid_in & bus.reg_write_in & (bus.rd_in != 5'd0) & ~(is_load & ld_bad) &
           (bus.wb_sel_in != 2'b11);
  end

  // WB register: flush squashes (rd/data hold), stall holds, else load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      we_q      <= 1'b0;
      rd_q      <= 5'd0;
      data_q    <= '0;
      fault_q   <= 1'b0;
      instret_q <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
    end else if (!bus.stall) begin
      valid_q <= bus.valid_in;
      we_q    <= we_d;
      rd_q    <= bus.rd_in;
      data_q  <= data_d;
      fault_q <= fault_d;
      if (bus.valid_in) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign bus.wb_valid      = valid_q;
  assign bus.wb_reg_write  = we_q;
  assign bus.wb_rd         = rd_q;
  assign bus.wb_data       = data_q;
  assign bus.wb_load_fault = fault_q;
  assign bus.instret       = instret_q;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and writeback-select block. Sits directly downstream of mem_stage.
- Takes the raw 32-bit word from mem_stage read_data, plus the EX/MEM control/data it was issued with.
- Performs load byte/half extraction and sign/zero extension, and selects the writeback source.
- Registers the result for the register file and forwarding unit, and keeps a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 32, width of the retire counter; wraps modulo 2^CNT_W.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid_in  input  1  a real instruction is present in MEM this cycle.
- stall  input  1  hold the WB register contents.
- flush  input  1  squash: load a bubble.
- reg_write_in  input  1  instruction writes rd.
- rd_in  input  5  destination register.
- wb_sel_in  input  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 reserved.
- funct3_in  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- alu_result_in  input  32  ALU result; for loads, the byte address.
- mem_data_in  input  32  word returned by mem_stage read_data (little-endian).
- pc_plus4_in  input  32  PC+4 of the instruction.
- wb_valid  output  1  registered valid.
- wb_reg_write  output  1  register-file write enable.
- wb_rd  output  5  register-file write address.
- wb_data  output  32  register-file write data.
- wb_load_fault  output  1  misaligned or illegal-funct3 load retired this entry.
- instret  output  CNT_W  count of retired instructions.

Behaviour:
- Reset (async, rst=1): all outputs cleared immediately, independent of clk.
  - wb_valid=0, wb_reg_write=0, wb_rd=0, wb_data=0, wb_load_fault=0, instret=0.
  - Reset mid-stall or mid-flush clears the same way.
- Latency: inputs sampled on a rising edge appear on the outputs after that edge. One cycle, no combinational input-to-output path.
- Update priority on each edge:
  1. flush: wb_valid, wb_reg_write and wb_load_fault are set to 0. wb_rd and wb_data hold their values.
  2. stall: all registers hold.
  3. Otherwise: the next entry is loaded from the inputs.
- flush together with stall: flush wins.
- Load extraction (wb_sel_in=01), with off = alu_result_in[1:0]:
  - LB/LBU: byte mem_data_in[8*off+7 : 8*off]. LB sign-extends; LBU zero-extends.
  - LH/LHU: half at off[1]; off[0] must be 0. LH sign-extends; LHU zero-extends.
  - LW: full word; off must be 00.
  - Any misalignment, or funct3 in {011,110,111}: fault=1, write suppressed, wb_data=0.
- Writeback select:
  - wb_sel 00: alu_result_in.
  - wb_sel 10: pc_plus4_in.
  - wb_sel 11: wb_data=0 and reg_write suppressed. This is not a fault.
- Write-enable rule: wb_reg_write = valid_in & reg_write_in & (rd_in != 0) & ~fault. A write to x0 is never issued.
- wb_load_fault is set only when valid_in=1 and wb_sel_in=01.
- instret increments by 1 on each edge that loads a new entry with valid_in=1. Faulting loads count.
  - No increment on stall, flush, or a bubble.
  - Wraps from all-ones to 0.
- With valid_in=0 and no stall/flush: a bubble is loaded (valid, reg_write and fault = 0); wb_rd and wb_data take the input-derived values.

Test Plan:
- mem_data_in=0xDEADBEEF for the load cases below.
- LB, addr 0x0B, rd=5 -> next edge: wb_data=0xFFFFFFDE, wb_rd=5, wb_reg_write=1, instret=1.
- LBU 0x09 -> 0x000000BE. LH 0x0A -> 0xFFFFDEAD. LHU 0x08 -> 0x0000BEEF. LW 0x08 -> 0xDEADBEEF.
- LW at 0x0A, and LH at 0x09 -> wb_load_fault=1, wb_reg_write=0, wb_data=0. instret still increments.
- ALU op, wb_sel=00, alu_result=0x12345678, rd=0 -> wb_data=0x12345678, wb_reg_write=0, wb_valid=1.
- JAL, wb_sel=10, pc_plus4=0x00000104, rd=1 -> wb_data=0x104, wb_reg_write=1.
  - Then stall=1 for 3 cycles with changing inputs: outputs and instret unchanged.
  - Then stall=1 and flush=1: wb_valid=0, wb_reg_write=0.
- Preload instret near all-ones, then retire 2 -> instret wraps to 0 after the first and reaches 1 after the second.
- Assert rst asynchronously between edges while wb_valid=1 -> all outputs 0 before the next edge.
